// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// burst sequencer state encoding and a shift-mode classification helper.
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_SET  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // True for the four modes a burst is allowed to repeat (SHL..ROR).
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ROR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_shift_step.sv
// One combinational step of the universal register: given the current value
// and an operation code, produce the value the register takes next.
module shift_step
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] nxt
);

  // Next-value selection for every operation code.
  always_comb begin
    nxt = q;
    case (op)
      MODE_HOLD: nxt = q;
      MODE_LOAD: nxt = d;
      MODE_SHL:  nxt = {q[WIDTH-2:0], sin_r};
      MODE_SHR:  nxt = {sin_l, q[WIDTH-1:1]};
      MODE_ROL:  nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  nxt = {q[0], q[WIDTH-1:1]};
      MODE_CLR:  nxt = {WIDTH{1'b0}};
      MODE_SET:  nxt = {WIDTH{1'b1}};
      default:   nxt = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register with hold/load/shift/rotate/clear/set modes
// and a burst sequencer that repeats one shift or rotate cnt times after a
// single start pulse. Optional registered parity output is enabled with the
// UNIV_SHIFT_REG_PARITY_EN macro.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
`ifdef UNIV_SHIFT_REG_PARITY_EN
  ,
  output logic             parity
`endif
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] rem_r;
  logic [CNT_W-1:0] rem_nxt_s;
  logic [2:0]       dir_r;
  logic [2:0]       dir_nxt_s;
  logic [2:0]       op_s;
  logic [WIDTH-1:0] next_q_s;

  // Single datapath step shared by direct modes and burst steps.
  shift_step #(.WIDTH(WIDTH)) u_step (
    .q     (Q),
    .op    (op_s),
    .d     (D),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .nxt   (next_q_s)
  );

  // Sequencer next state and selection of the operation applied to Q.
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    dir_nxt_s   = dir_r;
    op_s        = MODE_HOLD;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          // Q is left untouched on the edge that accepts a start.
          op_s = MODE_HOLD;
          if (is_shift_mode(mode) && (cnt != {CNT_W{1'b0}})) begin
            state_nxt_s = ST_SHIFT;
            rem_nxt_s   = cnt;
            dir_nxt_s   = mode;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          op_s = mode;
        end
      end
      ST_SHIFT: begin
        op_s      = dir_r;
        rem_nxt_s = rem_r - CNT_W'(1);
        if (rem_r == CNT_W'(1)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        op_s        = MODE_HOLD;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        op_s        = MODE_HOLD;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Register, complement, status flags and sequencer state; en=0 freezes all.
  always_ff @(posedge Clk) begin
    if (rst) begin
      Q       <= {WIDTH{1'b0}};
      nQ      <= {WIDTH{1'b1}};
      state_r <= ST_IDLE;
      rem_r   <= {CNT_W{1'b0}};
      dir_r   <= MODE_HOLD;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef UNIV_SHIFT_REG_PARITY_EN
      parity  <= 1'b0;
`endif
    end else if (en) begin
      Q       <= next_q_s;
      nQ      <= ~next_q_s;
      state_r <= state_nxt_s;
      rem_r   <= rem_nxt_s;
      dir_r   <= dir_nxt_s;
      busy    <= (state_nxt_s != ST_IDLE);
      done    <= (state_nxt_s == ST_DONE);
`ifdef UNIV_SHIFT_REG_PARITY_EN
      parity  <= ^next_q_s;
`endif
    end
  end

  assign sout_l = Q[WIDTH-1];
  assign sout_r = Q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4). Each step's
// stimulus carries its expected outcome; it is pushed to the scoreboard when
// driven and popped/compared one edge later. Parity checks are active when
// UNIV_SHIFT_REG_PARITY_EN is defined.
module tb_univ_shift_reg;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;
  localparam logic [2:0] M_SET  = 3'b111;

  logic       Clk = 1'b0;
  logic       rst, en, sin_l, sin_r, start;
  logic [2:0] mode;
  logic [7:0] D;
  logic [3:0] cnt;
  logic [7:0] Q, nQ;
  logic       sout_l, sout_r, busy, done;
`ifdef UNIV_SHIFT_REG_PARITY_EN
  logic       parity;
`endif

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic       rst, en, start;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl, sr;
    logic [3:0] cnt;
    logic [7:0] q;
    logic       busy, done;
  } step_t;

  step_t stim_q[$];
  step_t sb[$];

  univ_shift_reg dut (
    .Clk(Clk), .rst(rst), .en(en), .mode(mode), .D(D),
    .sin_l(sin_l), .sin_r(sin_r), .start(start), .cnt(cnt),
    .Q(Q), .nQ(nQ), .sout_l(sout_l), .sout_r(sout_r),
    .busy(busy), .done(done)
`ifdef UNIV_SHIFT_REG_PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 Clk = ~Clk;

  // Queue one stimulus step together with its expected outcome.
  task automatic add(input logic r, input logic e, input logic st, input logic [2:0] m,
                     input logic [7:0] dd, input logic sl, input logic sr, input logic [3:0] c,
                     input logic [7:0] q, input logic b, input logic dn);
    step_t s;
    s.rst = r; s.en = e; s.start = st; s.mode = m; s.d = dd;
    s.sl = sl; s.sr = sr; s.cnt = c; s.q = q; s.busy = b; s.done = dn;
    stim_q.push_back(s);
  endtask

  // Apply one queued step's inputs and record its expectation.
  task automatic apply_next();
    step_t s;
    s = stim_q.pop_front();
    rst = s.rst; en = s.en; start = s.start; mode = s.mode; D = s.d;
    sin_l = s.sl; sin_r = s.sr; cnt = s.cnt;
    sb.push_back(s);
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] q, input logic [2:0] m,
                                            input logic [7:0] dd, input logic sl, input logic sr);
    case (m)
      M_HOLD:  return q;
      M_LOAD:  return dd;
      M_SHL:   return (q << 1) | {7'd0, sr};
      M_SHR:   return (q >> 1) | {sl, 7'd0};
      M_ROL:   return {q[6:0], q[7]};
      M_ROR:   return {q[0], q[7:1]};
      M_CLR:   return 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic test_reset();
    step_t e;
    int i = 0;
    add(1'b1, 1'b1, 1'b0, M_LOAD, 8'hFF, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, M_LOAD, 8'hFF, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      apply_next();
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({Q, nQ, busy, done} !== {e.q, ~e.q, e.busy, e.done}) begin
        fails++;
        $display("FAIL reset[%0d]: got Q=%h nQ=%h busy=%b done=%b, want Q=%h nQ=%h busy=%b done=%b",
                 i, Q, nQ, busy, done, e.q, ~e.q, e.busy, e.done);
      end
`ifdef UNIV_SHIFT_REG_PARITY_EN
      checks++;
      if (parity !== 1'b0) begin
        fails++;
        $display("FAIL reset_parity[%0d]: got %b want 0", i, parity);
      end
`endif
      i++;
    end
  endtask

  task automatic test_direct();
    step_t e;
    int i = 0;
    add(1'b0, 1'b1, 1'b0, M_LOAD, 8'hA5, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_SHL,  8'h00, 1'b0, 1'b1, 4'd0, 8'h4B, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_SHR,  8'h00, 1'b0, 1'b0, 4'd0, 8'h25, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_SHR,  8'h00, 1'b1, 1'b0, 4'd0, 8'h92, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_CLR,  8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_SET,  8'h00, 1'b0, 1'b0, 4'd0, 8'hFF, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, M_LOAD, 8'h12, 1'b0, 1'b0, 4'd0, 8'hFF, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, M_ROL,  8'h12, 1'b0, 1'b0, 4'd3, 8'hFF, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_LOAD, 8'h81, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_ROR,  8'h00, 1'b0, 1'b0, 4'd0, 8'hC0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_ROL,  8'h00, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_HOLD, 8'h55, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      apply_next();
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({Q, nQ, busy, done, sout_l, sout_r} !== {e.q, ~e.q, e.busy, e.done, e.q[7], e.q[0]}) begin
        fails++;
        $display("FAIL direct[%0d]: got Q=%h nQ=%h busy=%b done=%b sout_l=%b sout_r=%b, want Q=%h nQ=%h busy=%b done=%b",
                 i, Q, nQ, busy, done, sout_l, sout_r, e.q, ~e.q, e.busy, e.done);
      end
      i++;
    end
  endtask

  task automatic test_parity();
    step_t e;
    int i = 0;
    add(1'b0, 1'b1, 1'b0, M_LOAD, 8'h07, 1'b0, 1'b0, 4'd0, 8'h07, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_SHL,  8'h00, 1'b0, 1'b0, 4'd0, 8'h0E, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_LOAD, 8'h03, 1'b0, 1'b0, 4'd0, 8'h03, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_SHL,  8'h00, 1'b0, 1'b1, 4'd0, 8'h07, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      apply_next();
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({Q, nQ, busy, done} !== {e.q, ~e.q, e.busy, e.done}) begin
        fails++;
        $display("FAIL parity_data[%0d]: got Q=%h nQ=%h, want Q=%h nQ=%h", i, Q, nQ, e.q, ~e.q);
      end
`ifdef UNIV_SHIFT_REG_PARITY_EN
      checks++;
      if (parity !== ^e.q) begin
        fails++;
        $display("FAIL parity[%0d]: got %b want %b", i, parity, ^e.q);
      end
`endif
      i++;
    end
  endtask

  task automatic test_burst_rol();
    step_t e;
    int i = 0;
    add(1'b0, 1'b1, 1'b0, M_LOAD, 8'h81, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, M_ROL,  8'h00, 1'b0, 1'b0, 4'd3, 8'h81, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_SET,  8'h00, 1'b0, 1'b0, 4'd0, 8'h03, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_SET,  8'h00, 1'b0, 1'b0, 4'd0, 8'h06, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_SET,  8'h00, 1'b0, 1'b0, 4'd0, 8'h0C, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, M_SET,  8'h00, 1'b0, 1'b0, 4'd0, 8'h0C, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h0C, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      apply_next();
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({Q, nQ, busy, done} !== {e.q, ~e.q, e.busy, e.done}) begin
        fails++;
        $display("FAIL burst_rol[%0d]: got Q=%h nQ=%h busy=%b done=%b, want Q=%h nQ=%h busy=%b done=%b",
                 i, Q, nQ, busy, done, e.q, ~e.q, e.busy, e.done);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back();
    step_t e;
    int i = 0;
    add(1'b0, 1'b1, 1'b1, M_ROL,  8'h00, 1'b0, 1'b0, 4'd0, 8'h0C, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h0C, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, M_LOAD, 8'hFF, 1'b0, 1'b0, 4'd3, 8'h0C, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h0C, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, M_SHL,  8'h00, 1'b0, 1'b1, 4'd2, 8'h0C, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, M_ROR,  8'h00, 1'b0, 1'b1, 4'd5, 8'h19, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, M_ROR,  8'h00, 1'b0, 1'b1, 4'd5, 8'h33, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, M_ROR,  8'h00, 1'b0, 1'b1, 4'd5, 8'h33, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h33, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      apply_next();
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({Q, nQ, busy, done} !== {e.q, ~e.q, e.busy, e.done}) begin
        fails++;
        $display("FAIL back_to_back[%0d]: got Q=%h nQ=%h busy=%b done=%b, want Q=%h nQ=%h busy=%b done=%b",
                 i, Q, nQ, busy, done, e.q, ~e.q, e.busy, e.done);
      end
      i++;
    end
  endtask

  task automatic test_en_pause();
    step_t e;
    int i = 0;
    add(1'b0, 1'b1, 1'b0, M_LOAD, 8'h01, 1'b0, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, M_ROR,  8'h00, 1'b0, 1'b0, 4'd4, 8'h01, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h80, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h80, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h80, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h40, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h20, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h10, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h10, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      apply_next();
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({Q, nQ, busy, done} !== {e.q, ~e.q, e.busy, e.done}) begin
        fails++;
        $display("FAIL en_pause[%0d]: got Q=%h nQ=%h busy=%b done=%b, want Q=%h nQ=%h busy=%b done=%b",
                 i, Q, nQ, busy, done, e.q, ~e.q, e.busy, e.done);
      end
      i++;
    end
  endtask

  task automatic test_reset_mid_burst();
    step_t e;
    int i = 0;
    add(1'b0, 1'b1, 1'b0, M_LOAD, 8'h01, 1'b0, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, M_ROR,  8'h00, 1'b0, 1'b0, 4'd4, 8'h01, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h80, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      apply_next();
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({Q, nQ, busy, done} !== {e.q, ~e.q, e.busy, e.done}) begin
        fails++;
        $display("FAIL reset_mid_burst[%0d]: got Q=%h nQ=%h busy=%b done=%b, want Q=%h nQ=%h busy=%b done=%b",
                 i, Q, nQ, busy, done, e.q, ~e.q, e.busy, e.done);
      end
      i++;
    end
  endtask

  task automatic test_random_direct();
    step_t e;
    logic [7:0] m;
    logic [2:0] md;
    logic [7:0] dd;
    logic       sl, sr, ee;
    m = 8'h00;
    for (int k = 0; k < 40; k++) begin
      md = 3'($urandom_range(7, 0));
      dd = 8'($urandom);
      sl = 1'($urandom);
      sr = 1'($urandom);
      ee = ($urandom_range(3, 0) != 0);
      if (ee) begin
        m = model_next(m, md, dd, sl, sr);
      end
      add(1'b0, ee, 1'b0, md, dd, sl, sr, 4'd0, m, 1'b0, 1'b0);
    end
    for (int k = 0; k < 40; k++) begin
      apply_next();
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({Q, nQ, busy, done, sout_l, sout_r} !== {e.q, ~e.q, e.busy, e.done, e.q[7], e.q[0]}) begin
        fails++;
        $display("FAIL random[%0d]: mode=%b en=%b got Q=%h nQ=%h busy=%b done=%b, want Q=%h",
                 k, e.mode, e.en, Q, nQ, busy, done, e.q);
      end
`ifdef UNIV_SHIFT_REG_PARITY_EN
      checks++;
      if (parity !== ^e.q) begin
        fails++;
        $display("FAIL random_parity[%0d]: got %b want %b", k, parity, ^e.q);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; mode = M_LOAD; D = 8'hFF;
    sin_l = 1'b0; sin_r = 1'b0; cnt = 4'd0;
    test_reset();
    test_direct();
    test_parity();
    test_burst_rol();
    test_back_to_back();
    test_en_pause();
    test_reset_mid_burst();
    test_random_direct();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
